// File: rtl/spdif_subframe_rx_if.sv
// spdif_subframe_rx_if: decoded subframe bundle from the S/PDIF front end.
// master = receiver, slave = downstream mixer/FIFO.
interface spdif_subframe_rx_if;
    logic [23:0] sample_o;
    logic [3:0]  ctl_o;
    logic        ch_o;
    logic        blk_o;
    logic        valid_o;
    logic        lock_o;
    logic        err_o;

    modport master (
        output sample_o, ctl_o, ch_o, blk_o,
        output valid_o, lock_o, err_o
    );

    modport slave (
        input sample_o, ctl_o, ch_o, blk_o,
        input valid_o, lock_o, err_o
    );
endinterface

// File: rtl/spdif_subframe_rx.sv
// spdif_subframe_rx: BMC edge-interval S/PDIF subframe decoder.
// Optional: define SPDIF_PARITY_CHECK_EN to reject odd-parity subframes.
module spdif_subframe_rx #(
    parameter int HALF_CLKS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spdif_i,
    spdif_subframe_rx_if.master rx
);
    localparam int WW = CNT_W + 1;
    localparam logic [WW-1:0] LIM_GL = WW'(HALF_CLKS);
    localparam logic [WW-1:0] LIM_1  = WW'(3 * HALF_CLKS);
    localparam logic [WW-1:0] LIM_2  = WW'(5 * HALF_CLKS);
    localparam logic [WW-1:0] LIM_3  = WW'(7 * HALF_CLKS);
    localparam logic [CNT_W-1:0] W_TO = CNT_W'((7 * HALF_CLKS) / 2 + 1);

    typedef enum logic [1:0] {HUNT, PRE, DATA, PREX} state_t;
    typedef enum logic [2:0] {C_GL, C_1T, C_2T, C_3T, C_LONG} cls_t;

    state_t state;
    cls_t cls, p0, p1;
    logic s1, s2, prev;
    logic [CNT_W-1:0] w;
    logic [WW-1:0] w2;
    logic [1:0] pcnt;
    logic [4:0] bcnt;
    logic half;
    logic [27:0] sh;
    logic [27:0] data_nx;
    logic ch_q, blk_q, good;
    logic edge_c, timeout;
    logic pre_b, pre_m, pre_w;
    logic bit_done, last_bit;
    logic err_c, par_err;

    assign edge_c = s2 ^ prev;
    assign w2 = {w, 1'b0};
    assign timeout = !edge_c && (w == W_TO);

    assign pre_b = (p0 == C_1T) && (p1 == C_1T) && (cls == C_3T);
    assign pre_m = (p0 == C_3T) && (p1 == C_1T) && (cls == C_1T);
    assign pre_w = (p0 == C_2T) && (p1 == C_1T) && (cls == C_2T);

    assign bit_done = (state == DATA) && edge_c &&
                      ((cls == C_1T && half) ||
                       (cls == C_2T && !half));
    assign last_bit = (bcnt == 5'd27);
    assign data_nx = {sh[26:0], cls == C_1T};

`ifdef SPDIF_PARITY_CHECK_EN
    assign par_err = bit_done && last_bit && (^data_nx);
`else
    assign par_err = 1'b0;
`endif

    // Classify the interval that ends at the current edge.
    always_comb begin
        cls = C_LONG;
        if (w2 < LIM_GL)
            cls = C_GL;
        else if (w2 <= LIM_1)
            cls = C_1T;
        else if (w2 <= LIM_2)
            cls = C_2T;
        else if (w2 <= LIM_3)
            cls = C_3T;
        else
            cls = C_LONG;
    end

    // Framing/timing error detection; HUNT tolerates anything.
    always_comb begin
        err_c = 1'b0;
        if (edge_c) begin
            unique case (state)
                HUNT: err_c = 1'b0;
                PRE: begin
                    if (pcnt == 2'd2)
                        err_c = !(pre_b || pre_m || pre_w);
                    else
                        err_c = (cls == C_GL) || (cls == C_LONG);
                end
                DATA: err_c = !((cls == C_1T) ||
                                (cls == C_2T && !half));
                PREX: err_c = (cls != C_3T);
            endcase
        end else begin
            err_c = timeout && (state != HUNT);
        end
    end

    // Synchronizer, interval counter, decode FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            prev        <= 1'b0;
            w           <= '0;
            state       <= HUNT;
            p0          <= C_GL;
            p1          <= C_GL;
            pcnt        <= '0;
            bcnt        <= '0;
            half        <= 1'b0;
            sh          <= '0;
            ch_q        <= 1'b0;
            blk_q       <= 1'b0;
            good        <= 1'b0;
            rx.sample_o <= '0;
            rx.ctl_o    <= '0;
            rx.ch_o     <= 1'b0;
            rx.blk_o    <= 1'b0;
            rx.valid_o  <= 1'b0;
            rx.lock_o   <= 1'b0;
            rx.err_o    <= 1'b0;
        end else begin
            s1   <= spdif_i;
            s2   <= s1;
            prev <= s2;
            if (edge_c)
                w <= CNT_W'(1);
            else if (w != '1)
                w <= w + 1'b1;
            rx.valid_o <= 1'b0;
            rx.err_o   <= 1'b0;
            if (err_c || par_err) begin
                rx.err_o  <= 1'b1;
                rx.lock_o <= 1'b0;
                good      <= 1'b0;
                half      <= 1'b0;
                pcnt      <= '0;
                state     <= par_err ? PREX : HUNT;
            end else if (edge_c) begin
                unique case (state)
                    HUNT: begin
                        if (cls == C_3T) begin
                            pcnt  <= '0;
                            state <= PRE;
                        end
                    end
                    PRE: begin
                        p0   <= p1;
                        p1   <= cls;
                        pcnt <= pcnt + 2'd1;
                        if (pcnt == 2'd2) begin
                            ch_q  <= pre_w;
                            blk_q <= pre_b;
                            bcnt  <= '0;
                            half  <= 1'b0;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (bit_done) begin
                            sh   <= data_nx;
                            bcnt <= bcnt + 5'd1;
                            half <= 1'b0;
                            if (last_bit) begin
                                rx.sample_o <= data_nx[27:4];
                                rx.ctl_o    <= data_nx[3:0];
                                rx.ch_o     <= ch_q;
                                rx.blk_o    <= blk_q;
                                rx.valid_o  <= 1'b1;
                                rx.lock_o   <= rx.lock_o | good;
                                good        <= 1'b1;
                                state       <= PREX;
                            end
                        end else begin
                            half <= 1'b1;
                        end
                    end
                    PREX: begin
                        pcnt  <= '0;
                        state <= PRE;
                    end
                endcase
            end
        end
    end
endmodule
